window_minimizer: RTL and testbench

// - Streaming sliding-window minimizer for the k-mer hash path. Parametrised successor to the fixed 49-entry min finder.
// - Accepts one k-mer hash per beat. Keeps the last WINDOW hashes. Emits the window minimum and its absolute k-mer position for every full window.
// - Sits between the k-mer hash stage and the minimizer/seed table writer. Sequences are delimited by in_last.

---
 rtl/window_minimizer_if.sv | 28 ++
 rtl/window_minimizer.sv | 148 ++++++++++++++
 tb/tb_window_minimizer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_minimizer_if.sv
// Stream interface for window_minimizer.
//   in_*  : k-mer hash beats from the hash stage (valid/ready, in_last closes a sequence)
//   out_* : window minimum and its position towards the seed table writer (valid/ready)
// Modports: slave = minimizer side, master = producer/consumer side (e.g. a testbench).
interface window_minimizer_if #(
  parameter int unsigned HASH_W = 32,
  parameter int unsigned POS_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [HASH_W-1:0] in_hash;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] out_min;
  logic [POS_W-1:0]  out_pos;
  logic              out_last;

  modport slave (
    input  in_valid, in_hash, in_last, out_ready,
    output in_ready, out_valid, out_min, out_pos, out_last
  );

  modport master (
    output in_valid, in_hash, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_pos, out_last
  );
endinterface

// File: rtl/window_minimizer.sv
// Streaming sliding-window minimizer.
// Keeps the last WINDOW k-mer hashes of a sequence and, for every full window (and once for a
// partial window closed by in_last), emits the minimum hash and its position in the sequence.
// Ports:
//   clk   - rising-edge clock
//   rstN  - asynchronous reset, active high
//   clear - synchronous flush of window, counters and output register
//   bus   - window_minimizer_if.slave (in_* input stream, out_* output stream)
// Optional feature: define MINIMIZER_DEDUP_EN to suppress an emit whose position equals the
// last handed-off position of the same sequence (the in_last beat is always emitted).
module window_minimizer #(
  parameter int unsigned HASH_W = 32,
  parameter int unsigned WINDOW = 49,
  parameter int unsigned POS_W  = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  window_minimizer_if.slave bus
);
  localparam int unsigned      FillW    = $clog2(WINDOW + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(WINDOW);

  // Entry 0 is the newest hash; higher indices are older.
  logic [HASH_W-1:0] win_hash_q [WINDOW];
  logic [POS_W-1:0]  win_pos_q  [WINDOW];
  logic [FillW-1:0]  fill_q;
  logic [POS_W-1:0]  pos_cnt_q;

  logic              out_valid_q;
  logic [HASH_W-1:0] out_min_q;
  logic [POS_W-1:0]  out_pos_q;
  logic              out_last_q;

  logic [HASH_W-1:0] sh_hash [WINDOW];
  logic [POS_W-1:0]  sh_pos  [WINDOW];
  logic [FillW-1:0]  fill_post;
  logic [HASH_W-1:0] min_hash;
  logic [POS_W-1:0]  min_pos;
  logic              in_ready, accept, handoff, emit_raw, emit;

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready && !clear;
  assign handoff   = out_valid_q && bus.out_ready;
  assign fill_post = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);

  // Window as it will look after this beat is shifted in.
  always_comb begin
    sh_hash[0] = bus.in_hash;
    sh_pos[0]  = pos_cnt_q;
    for (int i = 1; i < int'(WINDOW); i++) begin
      sh_hash[i] = win_hash_q[i-1];
      sh_pos[i]  = win_pos_q[i-1];
    end
  end

  // Scan newest to oldest; '<=' lets an older equal entry take over, so ties go to the oldest.
  always_comb begin
    min_hash = sh_hash[0];
    min_pos  = sh_pos[0];
    for (int i = 1; i < int'(WINDOW); i++) begin
      if (i < int'(fill_post) && sh_hash[i] <= min_hash) begin
        min_hash = sh_hash[i];
        min_pos  = sh_pos[i];
      end
    end
  end

  assign emit_raw = accept && (fill_post == FillFull || bus.in_last);

`ifdef MINIMIZER_DEDUP_EN
  logic             trk_valid_q;
  logic [POS_W-1:0] trk_pos_q;
  logic             prev_valid;
  logic [POS_W-1:0] prev_pos;

  // A beat handed off this very cycle counts as the last handoff, unless it closed the
  // previous sequence.
  assign prev_valid = handoff ? !out_last_q : trk_valid_q;
  assign prev_pos   = handoff ? out_pos_q : trk_pos_q;
  assign emit       = emit_raw && (bus.in_last || !prev_valid || prev_pos != min_pos);

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      trk_valid_q <= 1'b0;
      trk_pos_q   <= '0;
    end else if (clear || (accept && bus.in_last)) begin
      trk_valid_q <= 1'b0;
      trk_pos_q   <= '0;
    end else if (handoff && !out_last_q) begin
      trk_valid_q <= 1'b1;
      trk_pos_q   <= out_pos_q;
    end
  end
`else
  assign emit = emit_raw;
`endif

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      for (int i = 0; i < int'(WINDOW); i++) begin
        win_hash_q[i] <= '0;
        win_pos_q[i]  <= '0;
      end
      fill_q      <= '0;
      pos_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_pos_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < int'(WINDOW); i++) begin
        win_hash_q[i] <= '0;
        win_pos_q[i]  <= '0;
      end
      fill_q      <= '0;
      pos_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_pos_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < int'(WINDOW); i++) begin
          win_hash_q[i] <= sh_hash[i];
          win_pos_q[i]  <= sh_pos[i];
        end
        // in_last ends the sequence: the next beat starts at position 0 with an empty window.
        fill_q    <= bus.in_last ? '0 : fill_post;
        pos_cnt_q <= bus.in_last ? '0 : pos_cnt_q + POS_W'(1);
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_min_q   <= min_hash;
        out_pos_q   <= min_pos;
        out_last_q  <= bus.in_last;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_pos   = out_pos_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_window_minimizer.sv
// Testbench for window_minimizer (WINDOW=4, HASH_W=8, POS_W=8).
// A queue-based reference model tracks the expected output register every cycle; directed
// sequences pin the model with hand-computed handoff lists.
module tb_window_minimizer;
  localparam int unsigned HW  = 8;
  localparam int unsigned WIN = 4;
  localparam int unsigned PW  = 8;
  localparam int          PMOD = 1 << PW;

  logic clk = 1'b0;
  logic rstN;
  logic clear;

  always #5 clk = ~clk;

  window_minimizer_if #(.HASH_W(HW), .POS_W(PW)) bus ();

  window_minimizer #(.HASH_W(HW), .WINDOW(WIN), .POS_W(PW)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .clear (clear),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int q_hash[$];
  int q_pos[$];
  int seq_cnt;
  bit m_valid;
  int m_min;
  int m_pos;
  bit m_last;
  bit have_prev;
  int prev_pos;

  // Handoffs seen on the DUT, and hand-computed expectations, encoded min<<16 | pos<<1 | last
  int log_q[$];
  int exp_q[$];

  task automatic model_reset();
    q_hash.delete();
    q_pos.delete();
    seq_cnt   = 0;
    m_valid   = 1'b0;
    m_min     = 0;
    m_pos     = 0;
    m_last    = 1'b0;
    have_prev = 1'b0;
    prev_pos  = 0;
  endtask

  task automatic model_step();
    bit hand;
    bit rdy;
    bit emit;
    int mn;
    int mp;
    hand = m_valid && bus.out_ready;
    rdy  = !m_valid || bus.out_ready;
    if (clear) begin
      model_reset();
    end else if (bus.in_valid && rdy) begin
      q_hash.push_back(int'(bus.in_hash));
      q_pos.push_back(seq_cnt);
      seq_cnt++;
      if (q_hash.size() > WIN) begin
        void'(q_hash.pop_front());
        void'(q_pos.pop_front());
      end
      // Oldest first with strict '<': the oldest of equal minima wins.
      mn = q_hash[0];
      mp = q_pos[0];
      for (int i = 1; i < q_hash.size(); i++) begin
        if (q_hash[i] < mn) begin
          mn = q_hash[i];
          mp = q_pos[i];
        end
      end
      emit = (q_hash.size() == WIN) || bus.in_last;
`ifdef MINIMIZER_DEDUP_EN
      if (emit && !bus.in_last && have_prev && (mp % PMOD) == prev_pos) emit = 1'b0;
`endif
      if (emit) begin
        m_valid   = 1'b1;
        m_min     = mn;
        m_pos     = mp % PMOD;
        m_last    = bus.in_last;
        have_prev = 1'b1;
        prev_pos  = m_pos;
      end else if (hand) begin
        m_valid = 1'b0;
      end
      if (bus.in_last) begin
        q_hash.delete();
        q_pos.delete();
        seq_cnt   = 0;
        have_prev = 1'b0;
      end
    end else if (hand) begin
      m_valid = 1'b0;
    end
  endtask

  // Runs at the falling edge: compare DUT against model, then advance model for the next edge.
  task automatic cycle_check();
    bit exp_ready;
    if (rstN) model_reset();
    exp_ready = !m_valid || bus.out_ready;
    n_tests++;
    if (bus.out_valid !== m_valid || bus.in_ready !== exp_ready ||
        bus.out_min !== HW'(m_min) || bus.out_pos !== PW'(m_pos) || bus.out_last !== m_last) begin
      n_fail++;
      $display("FAIL cycle @%0t: got v=%0d rdy=%0d min=%0d pos=%0d last=%0d, expected v=%0d rdy=%0d min=%0d pos=%0d last=%0d",
               $time, bus.out_valid, bus.in_ready, bus.out_min, bus.out_pos, bus.out_last,
               m_valid, exp_ready, m_min, m_pos, m_last);
    end
    if (!rstN) begin
      if (bus.out_valid && bus.out_ready)
        log_q.push_back((int'(bus.out_min) << 16) | (int'(bus.out_pos) << 1) | int'(bus.out_last));
      model_step();
    end
  endtask

  task automatic step(bit v, int h, bit l, bit r, bit c, bit rs);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_hash   = HW'(h);
    bus.in_last   = l;
    bus.out_ready = r;
    clear         = c;
    rstN          = rs;
    @(negedge clk);
    cycle_check();
  endtask

  task automatic send(int h, bit l);
    step(1'b1, h, l, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    log_q.delete();
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_beat(int mn, int ps, bit lst);
    exp_q.push_back((mn << 16) | (ps << 1) | int'(lst));
  endtask

  task automatic check_log(string name);
    check({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_tests++;
      if (log_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s beat %0d: got min=%0d pos=%0d last=%0d, expected min=%0d pos=%0d last=%0d",
                 name, i, log_q[i] >> 16, (log_q[i] >> 1) & 16'h7fff, log_q[i] & 1,
                 exp_q[i] >> 16, (exp_q[i] >> 1) & 16'h7fff, exp_q[i] & 1);
      end
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int h;
    int sel;
    rstN          = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_hash   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();

    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_data", int'({bus.out_min, bus.out_pos, bus.out_last}), 0);
    check("reset_ready", int'(bus.in_ready), 1);
    idle(1);

    // Basic stream
    send(9, 0); send(5, 0); send(7, 0); send(6, 0); send(8, 0); send(3, 0);
    idle(3);
    expect_beat(5, 1, 0);
`ifndef MINIMIZER_DEDUP_EN
    expect_beat(5, 1, 0);
`endif
    expect_beat(3, 5, 0);
    check_log("stream");
    flush();

    // Ties resolve to the oldest
    send(4, 0); send(2, 0); send(2, 0); send(6, 0); send(2, 0);
    idle(3);
    expect_beat(2, 1, 0);
`ifndef MINIMIZER_DEDUP_EN
    expect_beat(2, 1, 0);
`endif
    check_log("ties");
    flush();

    // Short sequence, then the next sequence restarts at position 0
    send(7, 0); send(3, 1);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    idle(3);
    expect_beat(3, 1, 1);
    expect_beat(1, 0, 0);
    check_log("short_seq");
    flush();

    // Backpressure: output frozen, input stalled, nothing lost on release
    step(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_in_ready", int'(bus.in_ready), 0);
    check("bp_valid", int'(bus.out_valid), 1);
    check("bp_min", int'(bus.out_min), 5);
    check("bp_pos", int'(bus.out_pos), 0);
    step(1'b1, 9, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    expect_beat(5, 0, 0);
    expect_beat(6, 1, 0);
    check_log("backpressure");
    flush();

    // Async reset mid-stream, then clear overriding an accept
    send(5, 0); send(4, 0); send(3, 0); send(2, 0); send(1, 0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_data", int'({bus.out_min, bus.out_pos, bus.out_last}), 0);
    log_q.delete();
    step(1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clear_valid", int'(bus.out_valid), 0);
    send(9, 0); send(8, 0); send(7, 0); send(6, 0);
    idle(3);
    expect_beat(6, 3, 0);
    check_log("refill");
    flush();

    // Random traffic; the first phase has no in_last/clear so positions wrap past 2^POS_W.
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      h = 255;
      else if (sel == 1) h = $urandom_range(0, 255);
      else               h = $urandom_range(0, 15);
      step(($urandom_range(0, 9) < 7), h,
           (i >= 1500) && ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7),
           (i >= 1500) && ($urandom_range(0, 399) == 0),
           (i == 2500));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
